// File: rtl/counter_pkg.sv
// Shared constants and helpers for the free-running counter.
package counter_pkg;

    localparam int unsigned COUNT_WIDTH_DEFAULT = 4;
    localparam int unsigned COUNT_WIDTH_MAX     = 32;

    // All-ones terminal value for a counter of the given width (1..32).
    function automatic logic [31:0] all_ones(input int unsigned width);
        if (width >= 32) begin
            return 32'hFFFF_FFFF;
        end
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage : counter_pkg

// File: rtl/counter_reset_sync.sv
// Reset synchroniser: assertion passes through asynchronously, release is
// delayed by two rising clk edges.
//   clk          : block clock
//   reset        : raw asynchronous active-low reset
//   reset_sync_n : synchronised active-low reset, high two edges after release
module reset_sync (
    input  logic clk,
    input  logic reset,
    output logic reset_sync_n
);

    logic [1:0] r_sync;

    // Shift a 1 through two flops; raw reset clears both at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], 1'b1};
        end
    end

    assign reset_sync_n = r_sync[1];

endmodule : reset_sync

// File: rtl/counter.sv
// Free-running WIDTH-bit up-counter with a registered wrap pulse.
//   clk   : block clock, rising edge
//   reset : asynchronous active-low reset
//   count : registered count value, wraps modulo 2^WIDTH
//   wrap  : registered one-cycle pulse, high while count is 0 after rollover
module counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = COUNT_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    if (WIDTH == 0 || WIDTH > COUNT_WIDTH_MAX) begin : g_width_check
        $error("counter: WIDTH must be in the range 1..32");
    end

    localparam logic [WIDTH-1:0] TERMINAL = WIDTH'(all_ones(WIDTH));

    logic             w_reset_sync_n;
    logic             w_terminal;
    logic [WIDTH-1:0] r_count;
    logic             r_wrap;

    reset_sync u_reset_sync (
        .clk          (clk),
        .reset        (reset),
        .reset_sync_n (w_reset_sync_n)
    );

    assign w_terminal = (r_count == TERMINAL);

    // Count and wrap hold until the synchronised release; raw reset clears them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
            r_wrap  <= 1'b0;
        end else if (w_reset_sync_n) begin
            r_count <= r_count + WIDTH'(1);
            r_wrap  <= w_terminal;
        end
    end

    assign count = r_count;
    assign wrap  = r_wrap;

endmodule : counter

// File: tb/tb_counter.sv
module tb_counter;

    logic       clk = 1'b0;
    logic       reset;
    logic [0:0] count1;
    logic       wrap1;
    logic [3:0] count4;
    logic       wrap4;
    logic [7:0] count8;
    logic       wrap8;

    always #5 clk = ~clk;

    counter #(.WIDTH(1)) u_dut1 (.clk(clk), .reset(reset), .count(count1), .wrap(wrap1));
    counter #(.WIDTH(4)) u_dut4 (.clk(clk), .reset(reset), .count(count4), .wrap(wrap4));
    counter #(.WIDTH(8)) u_dut8 (.clk(clk), .reset(reset), .count(count8), .wrap(wrap8));

    typedef struct {
        logic [0:0] c1;
        logic       w1;
        logic [3:0] c4;
        logic       w4;
        logic [7:0] c8;
        logic       w8;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   edges = 0;   // rising edges seen with reset high since the last reset

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
        end
    endtask

    // Reference: after release the synchroniser eats two edges, every later
    // edge is one increment; n increments give count n mod 2^W and a wrap
    // whenever a positive n is a multiple of 2^W.
    function automatic exp_t model(input int e);
        exp_t r;
        int   n;
        n = (e >= 3) ? e - 2 : 0;
        r.c1 = 1'(n % 2);
        r.w1 = (n > 0) && (n % 2 == 0);
        r.c4 = 4'(n % 16);
        r.w4 = (n > 0) && (n % 16 == 0);
        r.c8 = 8'(n % 256);
        r.w8 = (n > 0) && (n % 256 == 0);
        return r;
    endfunction

    task automatic check_zero(input string tag);
        chk({tag, "_count1"}, 32'(count1), 32'd0);
        chk({tag, "_wrap1"},  32'(wrap1),  32'd0);
        chk({tag, "_count4"}, 32'(count4), 32'd0);
        chk({tag, "_wrap4"},  32'(wrap4),  32'd0);
        chk({tag, "_count8"}, 32'(count8), 32'd0);
        chk({tag, "_wrap8"},  32'(wrap8),  32'd0);
    endtask

    // mode 0: run, 1: reset held low through the next edge, 2: short glitch
    task automatic step(input int mode);
        @(negedge clk);
        case (mode)
            1: begin
                reset = 1'b0;
                #1 check_zero("async_rst");
                edges = 0;
            end
            2: begin
                reset = 1'b0;
                #1 check_zero("glitch_rst");
                #2 reset = 1'b1;
                edges = 1;
            end
            default: begin
                reset = 1'b1;
                edges++;
            end
        endcase
        q.push_back(model(edges));
    endtask

    // Monitor: compare each rising-edge result against the oldest expectation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("count1", 32'(count1), 32'(e.c1));
            chk("wrap1",  32'(wrap1),  32'(e.w1));
            chk("count4", 32'(count4), 32'(e.c4));
            chk("wrap4",  32'(wrap4),  32'(e.w4));
            chk("count8", 32'(count8), 32'(e.c8));
            chk("wrap8",  32'(wrap8),  32'(e.w8));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int r;
        reset = 1'b1;
        #1 reset = 1'b0;
        #1 check_zero("por");

        // Power-on reset for two cycles, then run through two 4-bit wraps.
        step(1);
        step(1);
        repeat (40) step(0);

        // Mid-count reset at count 1010, then restart.
        step(1);
        repeat (12) step(0);
        step(1);
        step(1);

        // Reset lands on the edge where 1111 would roll over: no wrap.
        repeat (17) step(0);
        step(1);
        repeat (5) step(0);

        // Sub-period glitch, then long run covering the 8-bit rollover.
        step(2);
        repeat (600) step(0);

        // Random mix of running, held resets and glitches.
        repeat (400) begin
            r = int'($urandom_range(0, 99));
            step((r < 90) ? 0 : ((r < 95) ? 1 : 2));
        end

        @(negedge clk);
        @(negedge clk);
        chk("queue_drain", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_counter
